pipe_sub: RTL and testbench
===========================

// Module: pipe_sub
// PURPOSE
//  Parametrised, pipelined WIDTH-bit subtractor built as a chain of full-subtractor slices:
//  diff = a - b - bin, with borrow-out and overflow flags.
//  The operand is split into STAGES equal chunks. Chunk k is resolved in pipeline stage k;
//  the borrow between chunks is carried in registers.
//  Sits in datapaths between valid/ready producers and consumers. Throughput is 1 op/cycle.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; must be divisible by STAGES
//  STAGES  2  pipeline depth (1..WIDTH); chunk width CW = WIDTH/STAGES
//  SIGNED  0  0: unsigned flag/saturation rules; 1: two's-complement rules
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      a/b/bin valid this cycle
//  in_ready   out  1      block accepts the input when in_valid & in_ready
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in to the LSB slice
//  out_valid  out  1      diff/bout/ovf valid
//  out_ready  in   1      consumer accepts the output when out_valid & out_ready
//  diff       out  WIDTH  result
//  bout       out  1      raw borrow-out of the MSB slice (never saturated)
//  ovf        out  1      SIGNED=0: equals bout; SIGNED=1: (a[W-1]!=b[W-1]) & (raw_diff[W-1]!=a[W-1])
// BEHAVIOUR
//  - Global advance: en = !out_valid | out_ready. When en=1, all stage registers load together.
//    When en=0, every stage holds its contents.
//  - in_ready = en & !rst. The block has no input skid buffer.
//  - Stage k (0..STAGES-1):
//    - Computes diff bits [k*CW +: CW] from the a/b chunk it carries and the borrow from stage k-1
//      (bin for k=0), using full-subtractor equations:
//      d = x^y^c; bo = (~x&y) | (~(x^y)&c).
//    - Carries the untouched upper a/b chunks forward and the finished lower diff bits forward.
//    - Each stage has its own valid bit. Bubbles propagate; they are not compacted.
//  - Latency: an input accepted at edge N appears on the outputs after edge N+STAGES-1,
//    i.e. it is visible at out_valid in the cycle that follows edge N+STAGES-1 when there is no stall.
//  - Output stays stable while out_valid & !out_ready.
//    Back-to-back accepts give back-to-back results with no loss or duplication.
//  - ovf and sign are evaluated on the raw (unsaturated) result in the final stage.
//  - Reset:
//    - All stage valids, out_valid, diff, bout and ovf are 0.
//    - in_ready is 0 while rst=1.
//  - Reset mid-operation: all in-flight operations are discarded; out_valid=0 in the cycle after rst.
//  - Full stall: with out_valid=1 and out_ready=0 the pipeline holds everything.
//    Up to STAGES operations stay held, in_ready=0, and nothing is overwritten.
//  - Simultaneous out_ready rise and in_valid: the output retires and the input is accepted on the same edge.
//  - Wrap-around (no macro): the result is modulo 2^WIDTH, e.g. 0x00-0x01 -> 0xFF.
//  - Elaboration check: WIDTH % STAGES != 0 or STAGES < 1 is a fatal error ($error in an initial/generate block).
// CONFIGURATION
//  SUB_SAT_EN defined: the final stage saturates diff.
//   - SIGNED=0: bout=1 -> diff=0.
//   - SIGNED=1: ovf=1 -> diff = a[W-1] ? {1,0..0} (min) : {0,1..1} (max).
//   - bout and ovf still report the raw condition. Latency is unchanged.
//  SUB_SAT_EN undefined: diff is always the raw wrapped result; no saturation logic is generated.
// TESTING (WIDTH=8, STAGES=2 unless stated)
//  1. a=0x05 b=0x03 bin=0 -> diff=0x02 bout=0 ovf=0, out_valid 2 cycles after accept.
//  2. a=0x00 b=0x01 bin=0 -> raw diff=0xFF bout=1. With SUB_SAT_EN and SIGNED=0 -> diff=0x00 bout=1.
//     Also a=0x10 b=0x0F bin=1 -> diff=0x00 bout=0.
//  3. SIGNED=1, a=0x80 b=0x01 -> ovf=1, diff=0x7F (no macro) / 0x80 (SUB_SAT_EN).
//     Also a=0x7F b=0xFF -> ovf=1, diff=0x80 / 0x7F.
//  4. Stream 6 ops with in_valid held high while out_ready=0 for 3 cycles mid-stream
//     -> in_ready=0 during the stall; all 6 results come out in order, no loss or duplication.
//  5. Assert rst for 1 cycle with 2 ops in flight -> out_valid=0 next cycle, no stale result ever emitted.
//     First op after reset returns its correct result.
//  6. STAGES=1 and STAGES=8 (WIDTH=8), random a/b/bin with out_ready random
//     -> every result matches the reference model a-b-bin; latency equals STAGES.

Source files
------------

// File: rtl/pipe_sub.sv
// Pipelined WIDTH-bit subtractor (diff = a - b - bin), one operand chunk per stage; SUB_SAT_EN enables output saturation.
// Latency STAGES cycles, 1 op/cycle; a single global enable stalls every stage when the output is held (no skid buffer).
module pipe_sub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (STAGES > 0) ? WIDTH / STAGES : WIDTH;

    if (STAGES < 1 || (WIDTH % ((STAGES > 0) ? STAGES : 1)) != 0) begin : g_bad_cfg
        $error("pipe_sub: WIDTH must be divisible by STAGES and STAGES >= 1");
    end

    function automatic logic [CW:0] f_sub(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                          input logic c);
        logic [CW-1:0] d;
        logic          bo;
        d  = '0;
        bo = c;
        for (int i = 0; i < CW; i++) begin
            d[i] = x[i] ^ y[i] ^ bo;
            bo   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bo);
        end
        return {bo, d};
    endfunction

    logic             w_en;
    logic [WIDTH-1:0] w_raw;
    logic             w_braw;
    logic             w_am;
    logic             w_bm;
    logic             w_vl;
    logic             w_ovf;
    logic [WIDTH-1:0] w_fin;

    logic             r_ov;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    assign w_en     = !r_ov | out_ready;
    assign in_ready = w_en & !rst;

    // Each stage sees one combined vector: untouched a bits above its chunk, finished diff bits below.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int RW = WIDTH - k * CW;

        logic [WIDTH-1:0] w_i;
        logic [WIDTH-1:0] w_o;
        logic [RW-1:0]    w_ib;
        logic             w_ci;
        logic             w_vi;
        logic [CW:0]      w_r;

        if (k == 0) begin : g_in
            assign w_i  = a;
            assign w_ib = b;
            assign w_ci = bin;
            assign w_vi = in_valid;
        end else begin : g_pv
            assign w_i  = g_stg[k-1].g_mid.r_x;
            assign w_ib = g_stg[k-1].g_mid.r_bu;
            assign w_ci = g_stg[k-1].g_mid.r_c;
            assign w_vi = g_stg[k-1].g_mid.r_v;
        end

        assign w_r = f_sub(w_i[k*CW +: CW], w_ib[CW-1:0], w_ci);

        always_comb begin
            w_o              = w_i;
            w_o[k*CW +: CW]  = w_r[CW-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0]   r_x;
            logic [RW-CW-1:0]   r_bu;
            logic               r_c;
            logic               r_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_x  <= '0;
                    r_bu <= '0;
                    r_c  <= 1'b0;
                    r_v  <= 1'b0;
                end else if (w_en) begin
                    r_x  <= w_o;
                    r_bu <= w_ib[RW-1:CW];
                    r_c  <= w_r[CW];
                    r_v  <= w_vi;
                end
            end
        end else begin : g_last
            assign w_raw  = w_o;
            assign w_braw = w_r[CW];
            assign w_am   = w_i[WIDTH-1];
            assign w_bm   = w_ib[RW-1];
            assign w_vl   = w_vi;
        end
    end

    assign w_ovf = (SIGNED != 0) ? ((w_am != w_bm) & (w_raw[WIDTH-1] != w_am)) : w_braw;

    always_comb begin
        w_fin = w_raw;
`ifdef SUB_SAT_EN
        if (SIGNED != 0) begin
            if (w_ovf)
                w_fin = w_am ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else if (w_braw) begin
            w_fin = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ov   <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_en) begin
            r_ov   <= w_vl;
            r_diff <= w_fin;
            r_bout <= w_braw;
            r_ovf  <= w_ovf;
        end
    end

    assign out_valid = r_ov;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_sub.sv
// Bench for pipe_sub: directed vector table on 8-bit/2-stage unsigned and signed instances,
// stall/reset sequences, and 1-stage/8-stage instances against an arithmetic reference.
module tb_pipe_sub;

`ifdef SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       d_vld, d_bin, d_ordy;
    logic [7:0] d_a, d_b;
    logic       r_vld, r_bin, r_ordy;
    logic [7:0] r_a, r_b;

    logic       u_ird, u_ov, u_bout, u_ovf;
    logic [7:0] u_diff;
    logic       s_ird, s_ov, s_bout, s_ovf;
    logic [7:0] s_diff;
    logic       p1_ird, p1_ov, p1_bout, p1_ovf;
    logic [7:0] p1_diff;
    logic       p8_ird, p8_ov, p8_bout, p8_ovf;
    logic [7:0] p8_diff;

    pipe_sub #(.WIDTH(8), .STAGES(2), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(d_vld), .in_ready(u_ird), .a(d_a), .b(d_b), .bin(d_bin),
        .out_valid(u_ov), .out_ready(d_ordy), .diff(u_diff), .bout(u_bout), .ovf(u_ovf));
    pipe_sub #(.WIDTH(8), .STAGES(2), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(d_vld), .in_ready(s_ird), .a(d_a), .b(d_b), .bin(d_bin),
        .out_valid(s_ov), .out_ready(d_ordy), .diff(s_diff), .bout(s_bout), .ovf(s_ovf));
    pipe_sub #(.WIDTH(8), .STAGES(1), .SIGNED(0)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(r_vld), .in_ready(p1_ird), .a(r_a), .b(r_b), .bin(r_bin),
        .out_valid(p1_ov), .out_ready(r_ordy), .diff(p1_diff), .bout(p1_bout), .ovf(p1_ovf));
    pipe_sub #(.WIDTH(8), .STAGES(8), .SIGNED(0)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(r_vld), .in_ready(p8_ird), .a(r_a), .b(r_b), .bin(r_bin),
        .out_valid(p8_ov), .out_ready(r_ordy), .diff(p8_diff), .bout(p8_bout), .ovf(p8_ovf));

    typedef struct {
        logic [7:0] a, b;
        logic       bin;
        logic [7:0] ud_raw, ud_sat;
        logic       bo;
        logic [7:0] sd_raw, sd_sat;
        logic       so;
    } vec_t;

    vec_t tbl[10];
    int   checks = 0;
    int   errors = 0;
    logic [8:0] q1[$];
    logic [8:0] q8[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        t = {1'b0, x} - {1'b0, y} - {8'b0, c};
        if (SAT && t[8]) t[7:0] = 8'h00;
        return t;
    endfunction

    task automatic do_op(input vec_t v, input int i);
        @(negedge clk);
        d_a = v.a; d_b = v.b; d_bin = v.bin; d_vld = 1'b1; d_ordy = 1'b1;
        #1 chk($sformatf("in_ready[%0d]", i), u_ird, 1);
        @(negedge clk);
        d_vld = 1'b0;
        #1 chk($sformatf("lat_early[%0d]", i), u_ov, 0);
        @(negedge clk);
        #1;
        chk($sformatf("out_valid[%0d]", i), u_ov, 1);
        chk($sformatf("diff[%0d]", i), u_diff, SAT ? v.ud_sat : v.ud_raw);
        chk($sformatf("bout[%0d]", i), u_bout, v.bo);
        chk($sformatf("ovf[%0d]", i), u_ovf, v.bo);
        chk($sformatf("s_valid[%0d]", i), s_ov, 1);
        chk($sformatf("s_diff[%0d]", i), s_diff, SAT ? v.sd_sat : v.sd_raw);
        chk($sformatf("s_bout[%0d]", i), s_bout, v.bo);
        chk($sformatf("s_ovf[%0d]", i), s_ovf, v.so);
    endtask

    task automatic rand_step(input bit drain);
        logic [8:0] e;
        @(negedge clk);
        r_vld  = drain ? 1'b0 : (($urandom % 3) != 0);
        r_a    = 8'($urandom);
        r_b    = 8'($urandom);
        r_bin  = 1'($urandom);
        r_ordy = drain ? 1'b1 : (($urandom % 4) != 0);
        #1;
        if (r_vld && p1_ird) q1.push_back(model(r_a, r_b, r_bin));
        if (r_vld && p8_ird) q8.push_back(model(r_a, r_b, r_bin));
        if (p1_ov && r_ordy) begin
            chk("s1_expected_output", (q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("s1_result", {p1_bout, p1_diff}, e);
                chk("s1_ovf", p1_ovf, e[8]);
            end
        end
        if (p8_ov && r_ordy) begin
            chk("s8_expected_output", (q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("s8_result", {p8_bout, p8_diff}, e);
                chk("s8_ovf", p8_ovf, e[8]);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sa[6], sb[6];
        logic       sbin[6];
        logic [8:0] se[6];
        int         sent, recv, stale, l1, l8;
        logic [8:0] e;

        //          a      b      bin   ud_raw ud_sat bo    sd_raw sd_sat so
        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 8'h02, 1'b0, 8'h02, 8'h02, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0};
        tbl[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 8'h7F, 1'b0, 8'h7F, 8'h80, 1'b1};
        tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 8'h00, 1'b1, 8'h80, 8'h7F, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0};
        tbl[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 8'h4B, 1'b0, 8'h4B, 8'h80, 1'b1};
        tbl[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0};
        tbl[8] = '{8'h0F, 8'h01, 1'b1, 8'h0D, 8'h0D, 1'b0, 8'h0D, 8'h0D, 1'b0};
        tbl[9] = '{8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};

        rst = 1'b1;
        d_vld = 1'b0; d_a = '0; d_b = '0; d_bin = 1'b0; d_ordy = 1'b1;
        r_vld = 1'b0; r_a = '0; r_b = '0; r_bin = 1'b0; r_ordy = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", u_ov, 0);
        chk("rst_in_ready", u_ird, 0);
        chk("rst_diff", u_diff, 0);
        chk("rst_bout", u_bout, 0);
        chk("rst_ovf", u_ovf, 0);
        chk("rst_s8_in_ready", p8_ird, 0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", u_ird, 1);

        for (int i = 0; i < 10; i++) do_op(tbl[i], i);

        // Stream of six with a three-cycle output stall in the middle
        for (int i = 0; i < 6; i++) begin
            sa[i]   = 8'(i * 37 + 5);
            sb[i]   = 8'(i * 53 + 17);
            sbin[i] = 1'(i);
            se[i]   = model(sa[i], sb[i], sbin[i]);
        end
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            @(negedge clk);
            d_vld  = (sent < 6);
            d_a    = sa[(sent < 6) ? sent : 0];
            d_b    = sb[(sent < 6) ? sent : 0];
            d_bin  = sbin[(sent < 6) ? sent : 0];
            d_ordy = !(cyc >= 3 && cyc < 6);
            #1;
            if (!d_ordy) begin
                chk("stall_in_ready", u_ird, 0);
                chk("stall_out_valid", u_ov, 1);
                chk("stall_hold", {u_bout, u_diff}, se[recv]);
            end
            if (u_ov && d_ordy) begin
                chk($sformatf("stream[%0d]", recv), {u_bout, u_diff}, se[recv]);
                recv++;
            end
            if (d_vld && u_ird) sent++;
        end
        chk("stream_count", recv, 6);
        @(negedge clk);
        d_vld = 1'b0;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            #1 if (u_ov) stale++;
        end
        chk("stream_no_dup", stale, 0);

        // Reset with two ops in flight
        @(negedge clk);
        d_ordy = 1'b0; d_vld = 1'b1; d_a = 8'h44; d_b = 8'h11; d_bin = 1'b0;
        @(negedge clk);
        d_a = 8'h99; d_b = 8'h22;
        #1 chk("inflight_accept", u_ird, 1);
        @(negedge clk);
        d_vld = 1'b0; rst = 1'b1;
        #1 chk("rst_mid_in_ready", u_ird, 0);
        @(negedge clk);
        #1 chk("rst_mid_out_valid", u_ov, 0);
        rst = 1'b0; d_ordy = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            #1 if (u_ov) stale++;
        end
        chk("rst_no_stale", stale, 0);
        do_op(tbl[6], 60);

        // Latency of the 1-stage and 8-stage builds with no stall
        l1 = -1; l8 = -1;
        @(negedge clk);
        r_vld = 1'b1; r_a = 8'h3C; r_b = 8'h15; r_bin = 1'b1; r_ordy = 1'b1;
        e = model(8'h3C, 8'h15, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            r_vld = 1'b0;
            #1;
            if (p1_ov && l1 < 0) begin
                l1 = n;
                chk("s1_lat_result", {p1_bout, p1_diff}, e);
            end
            if (p8_ov && l8 < 0) begin
                l8 = n;
                chk("s8_lat_result", {p8_bout, p8_diff}, e);
            end
        end
        chk("s1_latency", l1, 0);
        chk("s8_latency", l8, 7);

        for (int c = 0; c < 400; c++) rand_step(1'b0);
        for (int c = 0; c < 20; c++) rand_step(1'b1);
        chk("s1_drained", q1.size(), 0);
        chk("s8_drained", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
